// File: rtl/core_if.sv
// core_if: instruction-fetch stage.
// Owns the PC, issues in-order word fetches on ib_*, buffers returned words in
// a FIFO and hands them to decode on the fd_* valid/ready stream. A flush from
// ex redirects the PC and discards every fetch still in flight.
// Optional static branch prediction is enabled by defining CORE_IF_BPU_EN.
module core_if #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rest,
    output logic        ib_req_valid,
    input  logic        ib_req_ready,
    output logic [31:0] ib_req_addr,
    input  logic        ib_rsp_valid,
    input  logic [31:0] ib_rsp_data,
    input  logic        ex_flush_en,
    input  logic [31:0] ex_flush_pc,
    output logic        fd_valid,
    input  logic        fd_ready,
    output logic [31:0] fd_istr,
    output logic [31:0] fd_pc,
    output logic        fd_jump
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

    // Control state (reset)
    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] out_q, out_d;
    logic [CW-1:0] disc_q, disc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [PW-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;

    // Data storage (not reset; only read behind a valid count)
    logic [31:0] istr_mem [FIFO_DEPTH];
    logic [31:0] pc_mem   [FIFO_DEPTH];
    logic        jmp_mem  [FIFO_DEPTH];
    logic [31:0] tag_mem  [FIFO_DEPTH];

    logic        credit_ok, req_fire, rsp_keep, fifo_wr, fifo_rd;
    logic        pred_taken;
    logic [31:0] tag_pc, pred_tgt;
    logic        unused_flush_lsbs;

    // Redirect targets are word aligned; the low bits carry no information.
    assign unused_flush_lsbs = &{1'b0, ex_flush_pc[1:0]};

    assign tag_pc    = tag_mem[tag_rd_q];
    assign rsp_keep  = ib_rsp_valid && (disc_q == '0) && !ex_flush_en;
    assign fifo_wr   = rsp_keep;
    assign fifo_rd   = fd_valid && fd_ready && !ex_flush_en;

    // Outstanding fetches plus buffered words may never exceed the buffer,
    // which is what guarantees a response always has somewhere to land.
    assign credit_ok    = ({1'b0, out_q} + {1'b0, cnt_q}) < DEPTH_W;
    assign ib_req_valid = rest && credit_ok && !ex_flush_en && !pred_taken;
    assign ib_req_addr  = pc_q;
    assign req_fire     = ib_req_valid && ib_req_ready;

    assign fd_valid = (cnt_q != '0);
    assign fd_istr  = fd_valid ? istr_mem[rd_q] : 32'h0;
    assign fd_pc    = fd_valid ? pc_mem[rd_q]   : 32'h0;
    assign fd_jump  = fd_valid ? jmp_mem[rd_q]  : 1'b0;

`ifdef CORE_IF_BPU_EN
    function automatic logic [31:0] j_imm(input logic [31:0] i);
        return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
    endfunction

    function automatic logic [31:0] b_imm(input logic [31:0] i);
        return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
    endfunction

    // Static prediction on the word being written: JAL always, backward branches.
    always_comb begin
        pred_taken = 1'b0;
        pred_tgt   = tag_pc;
        if (ib_rsp_data[6:2] == 5'b11011) begin
            pred_taken = rsp_keep;
            pred_tgt   = tag_pc + j_imm(ib_rsp_data);
        end else if (ib_rsp_data[6:2] == 5'b11000 && ib_rsp_data[31]) begin
            pred_taken = rsp_keep;
            pred_tgt   = tag_pc + b_imm(ib_rsp_data);
        end
    end
`else
    assign pred_taken = 1'b0;
    assign pred_tgt   = tag_pc;
`endif

    // Next-state: sequential fetch, then prediction, then flush (highest priority).
    always_comb begin
        pc_d     = pc_q;
        out_d    = out_q + CW'(req_fire) - CW'(ib_rsp_valid);
        disc_d   = disc_q;
        tag_wr_d = tag_wr_q + PW'(req_fire);
        tag_rd_d = tag_rd_q + PW'(ib_rsp_valid);
        wr_d     = wr_q + PW'(fifo_wr);
        rd_d     = rd_q + PW'(fifo_rd);
        cnt_d    = cnt_q + CW'(fifo_wr) - CW'(fifo_rd);
        if (req_fire) begin
            pc_d = pc_q + 32'd4;
        end
        if (ib_rsp_valid && disc_q != '0) begin
            disc_d = disc_q - CW'(1);
        end
        if (pred_taken) begin
            pc_d   = pred_tgt;
            disc_d = out_d;
        end
        if (ex_flush_en) begin
            pc_d   = {ex_flush_pc[31:2], 2'b00};
            disc_d = out_d;
            cnt_d  = '0;
            wr_d   = '0;
            rd_d   = '0;
        end
    end

    // Control registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            pc_q     <= RESET_PC;
            out_q    <= '0;
            disc_q   <= '0;
            cnt_q    <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
            tag_wr_q <= '0;
            tag_rd_q <= '0;
        end else begin
            pc_q     <= pc_d;
            out_q    <= out_d;
            disc_q   <= disc_d;
            cnt_q    <= cnt_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            tag_wr_q <= tag_wr_d;
            tag_rd_q <= tag_rd_d;
        end
    end

    // Tag queue and instruction buffer storage.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            tag_mem[tag_wr_q] <= pc_q;
        end
        if (fifo_wr) begin
            istr_mem[wr_q] <= ib_rsp_data;
            pc_mem[wr_q]   <= tag_pc;
            jmp_mem[wr_q]  <= pred_taken;
        end
    end

    // A kept response must never land in a full buffer unless the head pops too.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rest)
        !(fifo_wr && (cnt_q == DEPTH_W[CW-1:0]) && !fifo_rd));

endmodule
